mtimecmp_irq: RTL
=================

// Module: mtimecmp_irq
// PURPOSE
//  Machine-timer compare stage fed by the mtime counter: holds the 64-bit mtimecmp register
//  (32-bit halves, written via active-low strobes). Compares it against the live mtime value
//  through a 2-stage split comparator and drives the machine timer interrupt pending bit (mtip)
//  to the core's interrupt logic.
// PARAMETERS
//  FLUSH_CYC   2               cycles mtip is held low after any mtimecmp write (>= compare pipeline depth)
//  CMP_RST     64'hFFFF_FFFF_FFFF_FFFF   reset value of mtimecmp (no interrupt out of reset)
// PORTS
//  clk         in   1   system clock, all state on rising edge
//  rst         in   1   reset, asynchronous, active-high
//  wrh_n       in   1   active-low write strobe, mtimecmp[63:32] <= mtimecmp_o
//  wrl_n       in   1   active-low write strobe, mtimecmp[31:0]  <= mtimecmp_o
//  mtimecmp_o  in   32  write data from core CSR/bus side
//  mtimerh_i   in   32  mtime[63:32] from mtime counter
//  mtimerl_i   in   32  mtime[31:0]  from mtime counter
//  mtimecmph_i out  32  mtimecmp[63:32] readback
//  mtimecmpl_i out  32  mtimecmp[31:0]  readback
//  mtip        out  1   machine timer interrupt pending, registered
// BEHAVIOUR
//  - Reset (async): mtimecmp = CMP_RST, stage-1 flags = 0, state = ARMED, flush cnt = 0, mtip = 0.
//  - Writes: strobe sampled at clk edge; readback shows new value the cycle after. Both strobes low
//    in one cycle -> both halves take mtimecmp_o. No byte masking.
//  - Compare stage 1 (registered, same-cycle snapshot of mtime and mtimecmp): hi_gt = mtimeh > cmph,
//    hi_eq = mtimeh == cmph, lo_ge = mtimel >= cmpl; all unsigned.
//  - Stage 2 (combinational): ge = hi_gt | (hi_eq & lo_ge). mtip is registered from FSM:
//    latency mtime-crosses-cmp -> mtip high = 2 clk edges.
//  - FSM states ARMED / FIRED / FLUSH:
//    ARMED: ge -> FIRED (mtip=1 next edge); any write -> FLUSH.
//    FIRED: any write -> FLUSH (mtip=0 next edge); !ge -> ARMED (non-sticky only).
//    FLUSH: mtip=0; counts FLUSH_CYC cycles, then -> ARMED; a write during FLUSH restarts the count.
//  - Write has priority over ge in every state (stale pipeline compare never fires).
//  - mtime wrap 2^64-1 -> 0: ge drops; non-sticky mtip falls 2 cycles later.
//  - mtimecmp = 0: fires after flush regardless of mtime. mtimecmp = all ones: fires only at mtime = all ones.
//  - Split-write hazard (low then high) is software's job; FLUSH covers only pipeline staleness.
// CONFIGURATION
//  MTIMECMP_STICKY_EN defined: FIRED is left only by a mtimecmp write (or rst); mtip stays 1
//    even if mtime wraps below mtimecmp.
//  Not defined: mtip is level-style, FIRED -> ARMED when ge deasserts (RISC-V privileged semantics).
// STRUCTURE
//  - Shared timer package/include (prv32_timer_defs): FSM state encodings ST_ARMED/ST_FIRED/ST_FLUSH
//    (2-bit), CMP_RST constant, timer data width 32; shared with mtime and bus decode.
//  - One sub-module: mtime_cmp_stage (stage-1 registers + stage-2 combine, outputs ge).
//    FSM, mtimecmp registers and flush counter stay in the top.
// TESTING
//  1 rst pulse mid-FIRED -> mtip 0 immediately (async); readback 32'hFFFFFFFF/32'hFFFFFFFF.
//  2 cmp=0x0000_0000_0000_0100, mtime counts from 0x0F0 -> mtip rises 2 edges after mtime=0x100.
//  3 FIRED, write cmpl=0xFFFF_FFFF -> mtip 0 next edge, held 0 for FLUSH_CYC even if ge true.
//  4 cmp=0x1_0000_0000, mtimel wraps 0xFFFF_FFFF->0, mtimeh 0->1 -> mtip rises at that crossing, not earlier.
//  5 wrh_n & wrl_n low together, data 0x0000_0005 -> readback both 0x5; mtime=0x5_0000_0005 fires.
//  6 FIRED, mtime forced 0 (wrap): non-sticky mtip falls after 2 cycles; MTIMECMP_STICKY_EN stays 1.

Source files
------------

// File: rtl/prv32_timer_defs_pkg.sv
// Shared machine-timer definitions: data width, mtimecmp reset value and compare FSM encodings.
// Used by the mtime counter, the mtimecmp compare stage and the bus decode.
package prv32_timer_defs_pkg;

  localparam int unsigned TMR_W = 32;
  localparam logic [63:0] CMP_RST_VAL = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    ST_ARMED = 2'd0,
    ST_FIRED = 2'd1,
    ST_FLUSH = 2'd2
  } tmr_state_e;

  typedef struct packed {
    logic [TMR_W-1:0] hi;
    logic [TMR_W-1:0] lo;
  } tmr64_t;

endpackage

// File: rtl/mtime_cmp_stage.sv
// Two-stage split 64-bit comparator: registered per-half flags, then a combinational
// merge giving mtime >= mtimecmp one cycle after the operands are presented.
module mtime_cmp_stage
  import prv32_timer_defs_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [TMR_W-1:0] mtimeh,
  input  logic [TMR_W-1:0] mtimel,
  input  logic [TMR_W-1:0] cmph,
  input  logic [TMR_W-1:0] cmpl,
  output logic             ge_c
);

  logic hi_gt;
  logic hi_eq;
  logic lo_ge;

  // Stage 1: snapshot both halves' relations in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_gt <= 1'b0;
      hi_eq <= 1'b0;
      lo_ge <= 1'b0;
    end else begin
      hi_gt <= (mtimeh > cmph);
      hi_eq <= (mtimeh == cmph);
      lo_ge <= (mtimel >= cmpl);
    end
  end

  assign ge_c = hi_gt | (hi_eq & lo_ge);

endmodule

// File: rtl/mtimecmp_irq.sv
// mtimecmp register pair plus ARMED/FIRED/FLUSH interrupt FSM driving mtip.
// Build option MTIMECMP_STICKY_EN: FIRED is left only by a mtimecmp write or reset.
module mtimecmp_irq
  import prv32_timer_defs_pkg::*;
#(
  parameter int unsigned FLUSH_CYC = 2,
  parameter logic [63:0] CMP_RST   = CMP_RST_VAL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wrh_n,
  input  logic             wrl_n,
  input  logic [TMR_W-1:0] mtimecmp_o,
  input  logic [TMR_W-1:0] mtimerh_i,
  input  logic [TMR_W-1:0] mtimerl_i,
  output logic [TMR_W-1:0] mtimecmph_i,
  output logic [TMR_W-1:0] mtimecmpl_i,
  output logic             mtip
);

  localparam int unsigned FLUSH_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_CYC - 1);

  tmr64_t             cmp_q;
  tmr_state_e         state_q, state_d;
  logic [FLUSH_W-1:0] cnt_q, cnt_d;
  logic               mtip_d;
  logic               wr_any_c;
  logic               ge_c;

  assign wr_any_c = ~wrh_n | ~wrl_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_q <= tmr64_t'(CMP_RST);
    end else begin
      if (!wrh_n) cmp_q.hi <= mtimecmp_o;
      if (!wrl_n) cmp_q.lo <= mtimecmp_o;
    end
  end

  assign mtimecmph_i = cmp_q.hi;
  assign mtimecmpl_i = cmp_q.lo;

  mtime_cmp_stage u_cmp (
    .clk    (clk),
    .rst    (rst),
    .mtimeh (mtimerh_i),
    .mtimel (mtimerl_i),
    .cmph   (cmp_q.hi),
    .cmpl   (cmp_q.lo),
    .ge_c   (ge_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ARMED;
      cnt_q   <= '0;
      mtip    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mtip    <= mtip_d;
    end
  end

  // A write always wins: the compare pipeline still holds the old mtimecmp.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (wr_any_c) begin
      state_d = ST_FLUSH;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_ARMED: if (ge_c) state_d = ST_FIRED;
        ST_FIRED: begin
`ifdef MTIMECMP_STICKY_EN
          state_d = ST_FIRED;
`else
          if (!ge_c) state_d = ST_ARMED;
`endif
        end
        ST_FLUSH: begin
          if (cnt_q == FLUSH_LAST) begin
            state_d = ST_ARMED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + FLUSH_W'(1);
          end
        end
        default: state_d = ST_ARMED;
      endcase
    end
    mtip_d = (state_d == ST_FIRED);
  end

endmodule
